// File: rtl/snoop_pkg.sv
// Shared types and encodings for the snoop bus controller and the caches on its bus.
package snoop_pkg;

  localparam int unsigned TypeW = 2;
  localparam int unsigned TagW  = 2;
  localparam int unsigned ValW  = 4;
  localparam int unsigned MsgW  = TypeW + TagW + ValW;

  localparam logic [TypeW-1:0] BusInvalidate = 2'b00;
  localparam logic [TypeW-1:0] BusReadMiss   = 2'b01;
  localparam logic [TypeW-1:0] BusWriteBack  = 2'b10;
  localparam logic [TypeW-1:0] BusReadHit    = 2'b11;

  localparam logic [1:0] PassoPh0 = 2'd0;
  localparam logic [1:0] PassoPh1 = 2'd1;
  localparam logic [1:0] PassoPh2 = 2'd2;
  localparam logic [1:0] PassoPh3 = 2'd3;

  typedef enum logic [2:0] {StIdle, StPh0, StPh1, StPh2, StPh3} snoop_state_e;

  typedef struct packed {
    logic [TypeW-1:0] btype;
    logic [TagW-1:0]  tag;
    logic [ValW-1:0]  value;
  } bus_msg_t;

  typedef struct packed {
    logic             op;
    logic [1:0]       origin;
    logic [TagW-1:0]  tag;
    logic [ValW-1:0]  value;
  } instr_t;

  // Idle shares the PH0 step so caches see a quiet bus between transactions.
  function automatic logic [1:0] state_passo(snoop_state_e st);
    case (st)
      StPh1:   return PassoPh1;
      StPh2:   return PassoPh2;
      StPh3:   return PassoPh3;
      default: return PassoPh0;
    endcase
  endfunction

endpackage

// File: rtl/snoop_bus_resolver.sv
// Fixed-priority bus resolver: lowest-indexed active cache wins; flags differing active messages.
module snoop_bus_resolver
  import snoop_pkg::*;
#(
  parameter logic [TypeW-1:0] ReadHit = BusReadHit
) (
  input  bus_msg_t cache_bus0_i,
  input  bus_msg_t cache_bus1_i,
  input  bus_msg_t cache_bus2_i,
  output bus_msg_t msg_o,
  output logic     conflict_o
);

  logic act0, act1, act2;

  assign act0 = (cache_bus0_i.btype != ReadHit);
  assign act1 = (cache_bus1_i.btype != ReadHit);
  assign act2 = (cache_bus2_i.btype != ReadHit);

  always_comb begin
    msg_o = '{btype: ReadHit, tag: '0, value: '0};
    if (act0) begin
      msg_o = cache_bus0_i;
    end else if (act1) begin
      msg_o = cache_bus1_i;
    end else if (act2) begin
      msg_o = cache_bus2_i;
    end
  end

  assign conflict_o = (act0 && act1 && (cache_bus0_i != cache_bus1_i)) ||
                      (act0 && act2 && (cache_bus0_i != cache_bus2_i)) ||
                      (act1 && act2 && (cache_bus1_i != cache_bus2_i));

endmodule

// File: rtl/snoop_bus_controller.sv
// Snoop bus controller: sequences four bus phases per instruction over a 4x4-bit backing memory.
// Define SNOOP_STATS_EN to add the txn_count / wb_count statistics outputs.
module snoop_bus_controller
  import snoop_pkg::*;
#(
  parameter logic [TypeW-1:0] READ_MISS  = BusReadMiss,
  parameter logic [TypeW-1:0] READ_HIT   = BusReadHit,
  parameter logic [TypeW-1:0] WRITE_BACK = BusWriteBack
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             instr_valid,
  input  logic [8:0]       instr,
  output logic             instr_ready,
  output logic [1:0]       passo,
  output logic [8:0]       instruction,
  input  logic [MsgW-1:0]  cache_bus0,
  input  logic [MsgW-1:0]  cache_bus1,
  input  logic [MsgW-1:0]  cache_bus2,
  output logic [MsgW-1:0]  in_bus,
  output logic             done,
  output logic             bus_error
`ifdef SNOOP_STATS_EN
  ,
  output logic [15:0]      txn_count,
  output logic [15:0]      wb_count
`endif
);

  snoop_state_e state_q, state_d;
  instr_t       instr_q, instr_d;
  bus_msg_t     in_bus_q, in_bus_d;
  logic         done_q, done_d;
  logic         bus_error_q, bus_error_d;
  logic [3:0][ValW-1:0] mem_q, mem_d;

  bus_msg_t res;
  logic     conflict;
  logic     res_wb;
  logic     res_is_req;

  snoop_bus_resolver #(
    .ReadHit (READ_HIT)
  ) u_resolver (
    .cache_bus0_i (bus_msg_t'(cache_bus0)),
    .cache_bus1_i (bus_msg_t'(cache_bus1)),
    .cache_bus2_i (bus_msg_t'(cache_bus2)),
    .msg_o        (res),
    .conflict_o   (conflict)
  );

  assign res_wb     = (res.btype == WRITE_BACK);
  assign res_is_req = (res.btype == READ_MISS) || (res.btype == BusInvalidate) ||
                      (res.btype == READ_HIT);

  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    in_bus_d    = in_bus_q;
    mem_d       = mem_q;
    done_d      = 1'b0;
    bus_error_d = bus_error_q | conflict;
    unique case (state_q)
      StIdle: begin
        if (instr_valid) begin
          instr_d = instr_t'(instr);
          state_d = StPh0;
        end
      end
      StPh0: begin
        state_d = StPh1;
        if (res_wb) mem_d[res.tag] = res.value;
      end
      StPh1: begin
        state_d = StPh2;
        // A write-back is not a request in this phase; the bus stays idle instead.
        in_bus_d = res_is_req ? res : '{btype: READ_HIT, tag: '0, value: '0};
      end
      StPh2: begin
        state_d = StPh3;
        if (res_wb) begin
          // The write-back itself is the fill, so a same-tag fill never sees stale memory.
          in_bus_d       = res;
          mem_d[res.tag] = res.value;
        end else begin
          in_bus_d = '{btype: READ_HIT, tag: instr_q.tag, value: mem_q[instr_q.tag]};
        end
      end
      StPh3: begin
        state_d = StIdle;
        done_d  = 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      instr_q     <= '0;
      in_bus_q    <= '{btype: READ_HIT, tag: '0, value: '0};
      done_q      <= 1'b0;
      bus_error_q <= 1'b0;
      mem_q       <= '0;
    end else begin
      state_q     <= state_d;
      instr_q     <= instr_d;
      in_bus_q    <= in_bus_d;
      done_q      <= done_d;
      bus_error_q <= bus_error_d;
      mem_q       <= mem_d;
    end
  end

  assign instr_ready = (state_q == StIdle);
  assign passo       = state_passo(state_q);
  assign instruction = instr_q;
  assign in_bus      = in_bus_q;
  assign done        = done_q;
  assign bus_error   = bus_error_q;

`ifdef SNOOP_STATS_EN
  logic [15:0] txn_count_q, txn_count_d;
  logic [15:0] wb_count_q, wb_count_d;
  logic        wb_accept;

  always_comb begin
    wb_accept   = res_wb && ((state_q == StPh0) || (state_q == StPh2));
    txn_count_d = txn_count_q + 16'(done_d);
    wb_count_d  = wb_count_q + 16'(wb_accept);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txn_count_q <= '0;
      wb_count_q  <= '0;
    end else begin
      txn_count_q <= txn_count_d;
      wb_count_q  <= wb_count_d;
    end
  end

  assign txn_count = txn_count_q;
  assign wb_count  = wb_count_q;
`endif

endmodule

// File: tb/tb_snoop_bus_controller.sv
// Self-checking bench for snoop_bus_controller: directed scenarios plus randomized transactions
// checked against a behavioural memory/bus model.
module tb_snoop_bus_controller;

  localparam logic [7:0]       IdleMsg = 8'hC0;
  localparam logic [2:0][7:0]  IdleBus = {3{IdleMsg}};

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       instr_valid = 1'b0;
  logic [8:0] instr = '0;
  logic       instr_ready;
  logic [1:0] passo;
  logic [8:0] instruction;
  logic [7:0] cache_bus0 = IdleMsg, cache_bus1 = IdleMsg, cache_bus2 = IdleMsg;
  logic [7:0] in_bus;
  logic       done;
  logic       bus_error;
`ifdef SNOOP_STATS_EN
  logic [15:0] txn_count, wb_count;
`endif

  int checks = 0;
  int errors = 0;

  logic [3:0] mdl_mem [4];
  bit         mdl_err;

  snoop_bus_controller dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .passo       (passo),
    .instruction (instruction),
    .cache_bus0  (cache_bus0),
    .cache_bus1  (cache_bus1),
    .cache_bus2  (cache_bus2),
    .in_bus      (in_bus),
    .done        (done),
    .bus_error   (bus_error)
`ifdef SNOOP_STATS_EN
    ,
    .txn_count   (txn_count),
    .wb_count    (wb_count)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  // Model: the first cache (0..2) not showing READ_HIT owns the bus, otherwise the idle message.
  function automatic logic [7:0] mdl_resolve(input logic [2:0][7:0] b);
    for (int i = 0; i < 3; i++) if (b[i][7:6] != 2'b11) return b[i];
    return IdleMsg;
  endfunction

  function automatic bit mdl_conflict(input logic [2:0][7:0] b);
    for (int i = 0; i < 3; i++)
      for (int j = i + 1; j < 3; j++)
        if (b[i][7:6] != 2'b11 && b[j][7:6] != 2'b11 && b[i] != b[j]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [7:0] rand_active(input bit allow_wb);
    logic [1:0] ty;
    case ($urandom_range(0, allow_wb ? 2 : 1))
      0:       ty = 2'b01;
      1:       ty = 2'b00;
      default: ty = 2'b10;
    endcase
    return {ty, 6'($urandom)};
  endfunction

  function automatic logic [3:0][2:0][7:0] gen_bus();
    logic [3:0][2:0][7:0] b;
    int c;
    for (int ph = 0; ph < 4; ph++)
      for (int k = 0; k < 3; k++) b[ph][k] = {2'b11, 6'($urandom)};
    for (int ph = 0; ph < 4; ph++) begin
      if ($urandom_range(0, 3) != 0) begin
        c = $urandom_range(0, 2);
        b[ph][c] = rand_active(ph != 1);
        if ($urandom_range(0, 15) == 0) b[ph][(c + 1) % 3] = rand_active(ph != 1);
      end
    end
    return b;
  endfunction

  task automatic drive_bus(input logic [2:0][7:0] b);
    cache_bus0 = b[0];
    cache_bus1 = b[1];
    cache_bus2 = b[2];
    if (mdl_conflict(b)) mdl_err = 1'b1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    instr_valid = 1'b0;
    drive_bus(IdleBus);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) mdl_mem[i] = 4'h0;
    mdl_err = 1'b0;
    @(negedge clk);
  endtask

  // Runs one full transaction starting at a negedge in IDLE; ends at the negedge after done.
  task automatic do_txn(input string name, input logic [8:0] ins, input logic [3:0][2:0][7:0] bus);
    logic [7:0] exp2, exp3, r;
    logic [1:0] t;
    t = ins[5:4];
    checks++;
    if (instr_ready !== 1'b1) begin
      errors++; $display("FAIL %s ready_idle got %b want 1", name, instr_ready);
    end
    instr_valid = 1'b1;
    instr = ins;
    drive_bus(IdleBus);
    @(negedge clk);
    instr_valid = 1'b0;
    instr = 9'($urandom);
    checks++;
    if (passo !== 2'd0 || instr_ready !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL %s ph0 got passo=%0d ready=%b done=%b want 0 0 0", name, passo, instr_ready,
               done);
    end
    checks++;
    if (instruction !== ins) begin
      errors++; $display("FAIL %s instruction got %h want %h", name, instruction, ins);
    end
    drive_bus(bus[0]);
    r = mdl_resolve(bus[0]);
    if (r[7:6] == 2'b10) mdl_mem[r[5:4]] = r[3:0];
    @(negedge clk);
    checks++;
    if (passo !== 2'd1) begin
      errors++; $display("FAIL %s passo_ph1 got %0d want 1", name, passo);
    end
    drive_bus(bus[1]);
    exp2 = mdl_resolve(bus[1]);
    @(negedge clk);
    checks++;
    if (passo !== 2'd2 || in_bus !== exp2) begin
      errors++;
      $display("FAIL %s ph2 got passo=%0d in_bus=%h want 2 %h", name, passo, in_bus, exp2);
    end
    drive_bus(bus[2]);
    r = mdl_resolve(bus[2]);
    if (r[7:6] == 2'b10) begin
      exp3 = r;
      mdl_mem[r[5:4]] = r[3:0];
    end else begin
      exp3 = {2'b11, t, mdl_mem[t]};
    end
    @(negedge clk);
    checks++;
    if (passo !== 2'd3 || in_bus !== exp3 || done !== 1'b0) begin
      errors++;
      $display("FAIL %s ph3 got passo=%0d in_bus=%h done=%b want 3 %h 0", name, passo, in_bus,
               done, exp3);
    end
    drive_bus(bus[3]);
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || instr_ready !== 1'b1 || in_bus !== exp3) begin
      errors++;
      $display("FAIL %s end got done=%b ready=%b in_bus=%h want 1 1 %h", name, done, instr_ready,
               in_bus, exp3);
    end
    checks++;
    if (bus_error !== mdl_err) begin
      errors++; $display("FAIL %s bus_error got %b want %b", name, bus_error, mdl_err);
    end
    drive_bus(IdleBus);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive_bus(IdleBus);
    repeat (2) @(negedge clk);
    checks++;
    if (instr_ready !== 1'b1 || passo !== 2'd0 || instruction !== 9'd0 || in_bus !== IdleMsg ||
        done !== 1'b0 || bus_error !== 1'b0) begin
      errors++;
      $display("FAIL reset_values got ready=%b passo=%0d instr=%h in_bus=%h done=%b err=%b",
               instr_ready, passo, instruction, in_bus, done, bus_error);
    end
    apply_reset();
    checks++;
    if (instr_ready !== 1'b1 || passo !== 2'd0 || in_bus !== IdleMsg || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_release got ready=%b passo=%0d in_bus=%h done=%b", instr_ready, passo,
               in_bus, done);
    end
  endtask

  task automatic test_read_miss();
    logic [3:0][2:0][7:0] b;
    b = {4{IdleBus}};
    b[1][0] = 8'h50;
    do_txn("read_miss", 9'b0_00_01_0000, b);
    checks++;
    if (in_bus !== 8'hD0) begin
      errors++; $display("FAIL read_miss_fill got %h want d0", in_bus);
    end
  endtask

  task automatic test_wb_ph0();
    logic [3:0][2:0][7:0] b;
    b = {4{IdleBus}};
    b[0][1] = 8'hAA;
    do_txn("wb_ph0", 9'b0_01_00_0000, b);
    b = {4{IdleBus}};
    b[1][0] = 8'h60;
    do_txn("wb_ph0_fill", 9'b0_00_10_0000, b);
    checks++;
    if (in_bus !== 8'hEA) begin
      errors++; $display("FAIL wb_ph0_fill_value got %h want ea", in_bus);
    end
  endtask

  task automatic test_wb_ph2();
    logic [3:0][2:0][7:0] b;
    b = {4{IdleBus}};
    b[1][0] = 8'h70;
    b[2][2] = 8'hB6;
    do_txn("wb_ph2", 9'b0_00_11_0000, b);
    checks++;
    if (in_bus !== 8'hB6) begin
      errors++; $display("FAIL wb_ph2_forward got %h want b6", in_bus);
    end
    b = {4{IdleBus}};
    do_txn("wb_ph2_mem", 9'b1_11_11_0101, b);
    checks++;
    if (in_bus !== 8'hF6) begin
      errors++; $display("FAIL wb_ph2_mem_value got %h want f6", in_bus);
    end
  endtask

  task automatic test_back_to_back();
    logic [8:0] a, b2;
    a  = 9'($urandom);
    b2 = 9'($urandom);
    instr_valid = 1'b1;
    instr = a;
    drive_bus(IdleBus);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      instr = (i == 5) ? b2 : 9'($urandom);
      checks++;
      if (instruction !== a || instr_ready !== (i == 5)) begin
        errors++;
        $display("FAIL b2b_hold cycle %0d got instr=%h ready=%b want %h %b", i, instruction,
                 instr_ready, a, (i == 5));
      end
    end
    @(negedge clk);
    instr_valid = 1'b0;
    checks++;
    if (instruction !== b2 || passo !== 2'd0 || instr_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second got instr=%h passo=%0d ready=%b want %h 0 0", instruction, passo,
               instr_ready, b2);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (done !== 1'b1) begin
      errors++; $display("FAIL b2b_done got %b want 1", done);
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int n = 0; n < 40; n++) do_txn("random", 9'($urandom), gen_bus());
  endtask

  task automatic test_conflict();
    logic [3:0][2:0][7:0] b;
    apply_reset();
    checks++;
    if (bus_error !== 1'b0) begin
      errors++; $display("FAIL conflict_clear got %b want 0", bus_error);
    end
    b = {4{IdleBus}};
    b[1][0] = 8'h50;
    b[1][1] = 8'h60;
    do_txn("conflict", 9'b0_00_01_0000, b);
    b = {4{IdleBus}};
    do_txn("conflict_sticky", 9'b0_10_10_0000, b);
    checks++;
    if (bus_error !== 1'b1) begin
      errors++; $display("FAIL conflict_sticky_flag got %b want 1", bus_error);
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0][2:0][7:0] b;
    instr_valid = 1'b1;
    instr = 9'b0_00_11_0000;
    drive_bus(IdleBus);
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    cache_bus0 = 8'h70;
    @(negedge clk);
    checks++;
    if (passo !== 2'd2 || in_bus !== 8'h70) begin
      errors++; $display("FAIL rstmid_ph2 got passo=%0d in_bus=%h want 2 70", passo, in_bus);
    end
    cache_bus0 = IdleMsg;
    cache_bus2 = 8'hBF;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (instr_ready !== 1'b1 || passo !== 2'd0 || instruction !== 9'd0 || in_bus !== IdleMsg ||
        done !== 1'b0 || bus_error !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_values got ready=%b passo=%0d instr=%h in_bus=%h done=%b err=%b",
               instr_ready, passo, instruction, in_bus, done, bus_error);
    end
    cache_bus2 = IdleMsg;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) mdl_mem[i] = 4'h0;
    mdl_err = 1'b0;
    @(negedge clk);
    checks++;
    if (instr_ready !== 1'b1) begin
      errors++; $display("FAIL rstmid_ready got %b want 1", instr_ready);
    end
    b = {4{IdleBus}};
    do_txn("rstmid_lost_write", 9'b0_00_11_0000, b);
    checks++;
    if (in_bus !== 8'hF0) begin
      errors++; $display("FAIL rstmid_mem got %h want f0", in_bus);
    end
  endtask

`ifdef SNOOP_STATS_EN
  task automatic test_stats();
    logic [3:0][2:0][7:0] b;
    apply_reset();
    b = {4{IdleBus}};
    b[0][0] = 8'hAA;
    do_txn("stats1", 9'b0_00_10_0000, b);
    b = {4{IdleBus}};
    b[2][1] = 8'hB6;
    do_txn("stats2", 9'b0_00_11_0000, b);
    b = {4{IdleBus}};
    do_txn("stats3", 9'b0_00_01_0000, b);
    checks++;
    if (txn_count !== 16'd3 || wb_count !== 16'd2) begin
      errors++; $display("FAIL stats_count got %0d %0d want 3 2", txn_count, wb_count);
    end
    force dut.txn_count_q = 16'hFFFF;
    force dut.wb_count_q  = 16'hFFFF;
    #1;
    release dut.txn_count_q;
    release dut.wb_count_q;
    b = {4{IdleBus}};
    b[0][0] = 8'hA5;
    do_txn("stats_wrap", 9'b0_00_10_0000, b);
    checks++;
    if (txn_count !== 16'd0 || wb_count !== 16'd0) begin
      errors++; $display("FAIL stats_wrap got %h %h want 0 0", txn_count, wb_count);
    end
  endtask
`endif

  initial begin
    mdl_err = 1'b0;
    for (int i = 0; i < 4; i++) mdl_mem[i] = 4'h0;
    test_reset();
    test_read_miss();
    test_wb_ph0();
    test_wb_ph2();
    test_back_to_back();
    test_random();
    test_conflict();
    test_reset_mid();
`ifdef SNOOP_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
